// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle between the VGA timing master and its pixel/overlay clients plus the pins.
// Latency: none (wires only).
// Backpressure: none; the client answer is sampled blindly at a fixed latency.
interface vga_timing_gen_if;
    logic [15:0] pixel_data;
    logic        data_req;
    logic [9:0]  pixel_xpos;
    logic [9:0]  pixel_ypos;
    logic        frame_start;
    logic        video_hs;
    logic        video_vs;
    logic        video_de;
    logic [15:0] video_rgb;

    modport master (
        input  pixel_data,
        output data_req, pixel_xpos, pixel_ypos, frame_start,
        output video_hs, video_vs, video_de, video_rgb
    );

    modport slave (
        output pixel_data,
        input  data_req, pixel_xpos, pixel_ypos, frame_start,
        input  video_hs, video_vs, video_de, video_rgb
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA display-timing master: sync/DE generation, pixel coordinate requests, client data alignment.
// Latency: counter to request stage 1 clk, counter to video pins PIX_LAT+2 clks.
// Backpressure: none; pixel_data is taken PIX_LAT clks after its coordinates without handshake.
module vga_timing_gen #(
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_DISP  = 640,
    parameter int H_FRONT = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_DISP  = 480,
    parameter int V_FRONT = 10,
    parameter int HS_POL  = 0,
    parameter int VS_POL  = 0,
    parameter int PIX_LAT = 1
) (
    input logic             clk,
    input logic             rst,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int H_START = H_SYNC + H_BACK;
    localparam int V_START = V_SYNC + V_BACK;

    // 10-bit counters cannot express longer lines/frames, and the delay line is bounded.
    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_chk
            $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL exceed 1024");
        end
        if (PIX_LAT < 0 || PIX_LAT > 4) begin : g_lat_chk
            $fatal(1, "vga_timing_gen: PIX_LAT outside 0..4");
        end
    endgenerate

    // 11-bit window bounds so an end bound of exactly 1024 still compares correctly.
    localparam logic [10:0] H_BEG_W = 11'(H_START);
    localparam logic [10:0] H_END_W = 11'(H_START + H_DISP);
    localparam logic [10:0] V_BEG_W = 11'(V_START);
    localparam logic [10:0] V_END_W = 11'(V_START + V_DISP);
    localparam logic [9:0]  H_OFS   = 10'(H_START);
    localparam logic [9:0]  V_OFS   = 10'(V_START);
    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_SYNC_W = 10'(H_SYNC);
    localparam logic [9:0]  V_SYNC_W = 10'(V_SYNC);
    localparam logic        HS_ACT  = (HS_POL != 0);
    localparam logic        VS_ACT  = (VS_POL != 0);

    // Bit positions of the raw flags travelling down the delay line.
    localparam int F_DE = 0;
    localparam int F_VS = 1;
    localparam int F_HS = 2;

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic        h_act, v_act, act;
    logic [2:0]  flags;
    logic [PIX_LAT:0][2:0] sr_q, sr_d;
    logic        data_req_q, frame_start_q;
    logic [9:0]  xpos_q, xpos_d;
    logic [9:0]  ypos_q, ypos_d;
    logic        hs_q, vs_q, de_q;
    logic [15:0] rgb_q;

    // Counter advance, active-window decode and next values for request stage and delay line.
    always_comb begin
        h_cnt_d = (h_cnt_q == H_LAST) ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        end

        h_act = ({1'b0, h_cnt_q} >= H_BEG_W) && ({1'b0, h_cnt_q} < H_END_W);
        v_act = ({1'b0, v_cnt_q} >= V_BEG_W) && ({1'b0, v_cnt_q} < V_END_W);
        act   = h_act && v_act;

        xpos_d = act   ? (h_cnt_q - H_OFS) : 10'd0;
        ypos_d = v_act ? (v_cnt_q - V_OFS) : 10'd0;

        flags       = 3'b000;
        flags[F_HS] = (h_cnt_q < H_SYNC_W);
        flags[F_VS] = (v_cnt_q < V_SYNC_W);
        flags[F_DE] = act;

        sr_d    = sr_q;
        sr_d[0] = flags;
        for (int i = 1; i <= PIX_LAT; i++) begin
            sr_d[i] = sr_q[i-1];
        end
    end

    // All state: counters, request stage, flag delay line and the pin register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            data_req_q    <= 1'b0;
            frame_start_q <= 1'b0;
            xpos_q        <= 10'd0;
            ypos_q        <= 10'd0;
            sr_q          <= '0;
            hs_q          <= ~HS_ACT;
            vs_q          <= ~VS_ACT;
            de_q          <= 1'b0;
            rgb_q         <= 16'h0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            data_req_q    <= act;
            frame_start_q <= (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
            xpos_q        <= xpos_d;
            ypos_q        <= ypos_d;
            sr_q          <= sr_d;
            hs_q          <= sr_q[PIX_LAT][F_HS] ? HS_ACT : ~HS_ACT;
            vs_q          <= sr_q[PIX_LAT][F_VS] ? VS_ACT : ~VS_ACT;
            de_q          <= sr_q[PIX_LAT][F_DE];
            // Client data is only trusted inside DE; blanking is forced to black.
            rgb_q         <= sr_q[PIX_LAT][F_DE] ? vga.pixel_data : 16'h0;
        end
    end

    assign vga.data_req    = data_req_q;
    assign vga.frame_start = frame_start_q;
    assign vga.pixel_xpos  = xpos_q;
    assign vga.pixel_ypos  = ypos_q;
    assign vga.video_hs    = hs_q;
    assign vga.video_vs    = vs_q;
    assign vga.video_de    = de_q;
    assign vga.video_rgb   = rgb_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a shrunken 13x8 raster.
// Latency: checks PIX_LAT+1 request-to-DE and closed-form frame positions.
// Backpressure: none; a modelled client answers coordinates after PIX_LAT clks.
module tb_vga_timing_gen;
    localparam int H_SYNC = 3, H_BACK = 2, H_DISP = 6, H_FRONT = 2;
    localparam int V_SYNC = 2, V_BACK = 2, V_DISP = 3, V_FRONT = 1;
    localparam int HS_POL = 0, VS_POL = 1, PIX_LAT = 2;
    // Hand-computed raster constants for the parameters above.
    localparam int HT = 13, VT = 8, FT = 104, HST = 5, VST = 4;
    localparam int FIRST_REQ_GAP = 57;   // 5 + 4*13
    localparam int REQ_TO_DE     = 3;    // PIX_LAT + 1
    localparam logic HS_A = 1'b0;
    localparam logic VS_A = 1'b1;
    localparam int CL_IDX = (PIX_LAT == 0) ? 0 : PIX_LAT - 1;

    logic clk = 1'b0;
    logic rst;
    logic force_ff;
    int   total = 0;
    int   bad   = 0;
    int   n_edges = 0;
    int   fs_n = -1, first_req_n = -1, last_req_rise = -1;
    logic prev_req = 1'b0, prev_de = 1'b0;
    logic [19:0] req_q[$];
    logic [15:0] rgb_q[$];
    logic [15:0] cl_pipe [0:4];

    always #5 clk = ~clk;

    vga_timing_gen_if vif();

    vga_timing_gen #(
        .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_DISP(H_DISP), .H_FRONT(H_FRONT),
        .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_DISP(V_DISP), .V_FRONT(V_FRONT),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .PIX_LAT(PIX_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .vga (vif)
    );

    function automatic logic [15:0] client_val(input logic [9:0] x, input logic [9:0] y);
        return {y[5:0], x};
    endfunction

    function automatic logic is_act(input int h, input int v);
        return (h >= HST) && (h < HST + H_DISP) && (v >= VST) && (v < VST + V_DISP);
    endfunction

    // Client: registered answer of the presented coordinates, PIX_LAT clks deep.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) cl_pipe[i] <= 16'h0;
        end else begin
            cl_pipe[0] <= client_val(vif.pixel_xpos, vif.pixel_ypos);
            for (int i = 1; i < 5; i++) cl_pipe[i] <= cl_pipe[i-1];
        end
    end

    assign vif.pixel_data = force_ff ? 16'hFFFF :
                            ((PIX_LAT == 0) ? client_val(vif.pixel_xpos, vif.pixel_ypos) : cl_pipe[CL_IDX]);

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_req", {10'd0, vif.data_req, vif.frame_start, vif.pixel_xpos, vif.pixel_ypos}, 32'd0);
        check("rst_vid", {29'd0, vif.video_hs, vif.video_vs, vif.video_de}, {29'd0, ~HS_A, ~VS_A, 1'b0});
        check("rst_rgb", {16'd0, vif.video_rgb}, 32'd0);
    endtask

    // Stimulus side: each clock the reference raster position of the request stage
    // is known; active positions push their expected coordinates and pixel value.
    always @(posedge clk) begin
        if (!rst) begin
            int p, h, v;
            n_edges = n_edges + 1;
            p = (n_edges - 1) % FT;
            h = p % HT;
            v = p / HT;
            if (is_act(h, v)) begin
                req_q.push_back({10'(v - VST), 10'(h - HST)});
                rgb_q.push_back(force_ff ? 16'hFFFF : client_val(10'(h - HST), 10'(v - VST)));
            end
        end
    end

    // Monitor: compares every clock against the closed-form raster and pops the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            int n, p, h, v, q;
            logic [2:0]  ev;
            logic [19:0] ec;
            logic [15:0] er;
            n = n_edges;
            if (n < 1) begin
                check("req_stage", {10'd0, vif.data_req, vif.frame_start, vif.pixel_xpos, vif.pixel_ypos}, 32'd0);
            end else begin
                p = (n - 1) % FT;
                h = p % HT;
                v = p / HT;
                check("req_stage", {10'd0, vif.data_req, vif.frame_start, vif.pixel_xpos, vif.pixel_ypos},
                      {10'd0, is_act(h, v), (p == 0),
                       is_act(h, v) ? 10'(h - HST) : 10'd0,
                       (v >= VST && v < VST + V_DISP) ? 10'(v - VST) : 10'd0});
            end
            q = n - PIX_LAT - 2;
            if (q < 0) begin
                ev = {~HS_A, ~VS_A, 1'b0};
            end else begin
                p = q % FT;
                h = p % HT;
                v = p / HT;
                ev = {(h < H_SYNC) ? HS_A : ~HS_A, (v < V_SYNC) ? VS_A : ~VS_A, is_act(h, v)};
            end
            check("video_sync", {29'd0, vif.video_hs, vif.video_vs, vif.video_de}, {29'd0, ev});

            if (vif.data_req) begin
                if (req_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL req_coord: data_req with no expected request at t=%0t", $time);
                end else begin
                    ec = req_q.pop_front();
                    check("req_coord", {12'd0, vif.pixel_ypos, vif.pixel_xpos}, {12'd0, ec});
                end
            end
            if (vif.video_de) begin
                if (rgb_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rgb: video_de with no expected pixel at t=%0t", $time);
                end else begin
                    er = rgb_q.pop_front();
                    check("rgb", {16'd0, vif.video_rgb}, {16'd0, er});
                end
            end else begin
                check("rgb_blank", {16'd0, vif.video_rgb}, 32'd0);
            end

            if (vif.frame_start) begin
                if (fs_n >= 0) check("fs_period", 32'(n - fs_n), 32'(FT));
                fs_n = n;
                first_req_n = -1;
            end
            if (vif.data_req && !prev_req) begin
                if (first_req_n < 0 && fs_n >= 0) begin
                    check("first_req_gap", 32'(n - fs_n), 32'(FIRST_REQ_GAP));
                    first_req_n = n;
                end
                last_req_rise = n;
            end
            if (vif.video_de && !prev_de && last_req_rise >= 0) begin
                check("req_to_de", 32'(n - last_req_rise), 32'(REQ_TO_DE));
            end
            prev_req = vif.data_req;
            prev_de  = vif.video_de;
        end
    end

    // Asynchronous reset away from the clock edge; outputs must drop before the next edge.
    task automatic do_reset(input logic frc);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_vals();
        req_q.delete();
        rgb_q.delete();
        n_edges       = 0;
        fs_n          = -1;
        first_req_n   = -1;
        last_req_rise = -1;
        prev_req      = 1'b0;
        prev_de       = 1'b0;
        force_ff      = frc;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        force_ff = 1'b0;
        #1 rst   = 1'b1;
        do_reset(1'b0);
        // Free run with the modelled client, then abort mid-frame (line 5, active pixel).
        repeat (2 * FT + 70) @(negedge clk);
        do_reset(1'b1);
        // Client stuck at all-ones: DE pixels show FFFF, blanking must stay black.
        repeat (2 * FT + 10) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
